dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 107 ++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: serves one lw/sw/ld/sd request at a time from a 32-bit synchronous-read word array.
// Latency from acceptance: error response 1 cycle, 32-bit access 2 cycles, 64-bit access 3 cycles.
// Backpressure: req_ready is low while busy (requests are not queued); the response has no backpressure.
module dmem_responder #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_dbl,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [63:0] resp_rdata
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT0 = 2'd1;
    localparam logic [1:0] S_BEAT1 = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state;
    logic          weQ;
    logic          dblQ;
    logic          errQ;
    logic [AW-1:0] idxQ;
    logic [63:0]   wdataQ;
    logic [31:0]   loQ;
    logic [31:0]   rdQ;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          misaligned;
    logic          outOfRange;
    logic [AW-1:0] accIdx;
    logic          memWe;
    logic [31:0]   wrWord;

    assign accept     = req_valid && (state == S_IDLE);
    assign misaligned = req_dbl ? (req_addr[2:0] != 3'd0) : (req_addr[1:0] != 2'd0);
    // Full-width index compare so high address bits can never alias into the array.
    assign outOfRange = (req_addr[63:2] >= 62'(DEPTH));

    // Second beat of a 64-bit access targets the odd word; DEPTH is even so it stays in range.
    assign accIdx = (state == S_BEAT1) ? (idxQ + AW'(1)) : idxQ;
    assign memWe  = weQ && ((state == S_BEAT0) || (state == S_BEAT1));
    assign wrWord = (state == S_BEAT1) ? wdataQ[63:32] : wdataQ[31:0];

    // Control FSM and captured request; reset aborts any access in flight without a response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            weQ    <= 1'b0;
            dblQ   <= 1'b0;
            errQ   <= 1'b0;
            idxQ   <= '0;
            wdataQ <= '0;
            loQ    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        weQ    <= req_we;
                        dblQ   <= req_dbl;
                        errQ   <= misaligned || outOfRange;
                        idxQ   <= req_addr[AW+1:2];
                        wdataQ <= req_wdata;
                        state  <= (misaligned || outOfRange) ? S_RESP : S_BEAT0;
                    end
                end
                S_BEAT0: state <= dblQ ? S_BEAT1 : S_RESP;
                S_BEAT1: begin
                    loQ   <= rdQ;
                    state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Word array: synchronous read every cycle, write only during a non-erroring store beat.
    always_ff @(posedge clk) begin
        if (memWe) begin
            mem[accIdx] <= wrWord;
        end
        rdQ <= mem[accIdx];
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_err   = (state == S_RESP) && errQ;

    // Read data is driven only on a successful load response, zero otherwise.
    always_comb begin
        resp_rdata = 64'd0;
        if ((state == S_RESP) && !errQ && !weQ) begin
            resp_rdata = dblQ ? {rdQ, loQ} : {{32{rdQ[31]}}, rdQ};
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic.
// Expected responses come from a word-array model with latency computed from the access kind.
// Requests are driven and outputs sampled on the falling clock edge.
module tb_dmem_responder;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_dbl = 1'b0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [63:0] resp_rdata;

    int total = 0;
    int bad = 0;

    logic [31:0] mdl [DEPTH];

    dmem_responder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_dbl    (req_dbl),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic dbl, input logic [63:0] addr);
        logic mis;
        mis = dbl ? (addr % 8 != 0) : (addr % 4 != 0);
        return mis || ((addr / 4) >= 64'(DEPTH));
    endfunction

    function automatic logic [63:0] model_rdata(input logic we, input logic dbl, input logic [63:0] addr);
        int i;
        if (we || model_err(dbl, addr)) return 64'd0;
        i = int'(addr / 4);
        if (dbl) return {mdl[i+1], mdl[i]};
        return {{32{mdl[i][31]}}, mdl[i]};
    endfunction

    function automatic int model_lat(input logic dbl, input logic [63:0] addr);
        if (model_err(dbl, addr)) return 1;
        return dbl ? 3 : 2;
    endfunction

    task automatic model_apply(input logic we, input logic dbl, input logic [63:0] addr, input logic [63:0] wdata);
        int i;
        if (!we || model_err(dbl, addr)) return;
        i = int'(addr / 4);
        mdl[i] = wdata[31:0];
        if (dbl) mdl[i+1] = wdata[63:32];
    endtask

    // One complete transaction: drive, wait (bounded) for the response, compare with the model.
    task automatic do_req(input string tag, input logic we, input logic dbl,
                          input logic [63:0] addr, input logic [63:0] wdata);
        int lat;
        int explat;
        logic [63:0] exprd;
        logic experr;
        explat = model_lat(dbl, addr);
        exprd  = model_rdata(we, dbl, addr);
        experr = model_err(dbl, addr);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_dbl = dbl; req_addr = addr; req_wdata = wdata;
        check({tag, ".ready"}, 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".valid"}, 64'(resp_valid), 64'd1);
        check({tag, ".lat"}, 64'(lat), 64'(explat));
        check({tag, ".err"}, 64'(resp_err), 64'(experr));
        check({tag, ".rdata"}, resp_rdata, exprd);
        model_apply(we, dbl, addr, wdata);
        @(negedge clk);
        check({tag, ".pulse"}, {63'd0, resp_valid} | resp_rdata, 64'd0);
    endtask

    initial begin
        int pulses;
        int first_resp;
        int second_resp;
        int ready_low;
        logic [63:0] exp_first;
        logic [63:0] exp_second;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.ready", 64'(req_ready), 64'd1);
        check("rst.valid", 64'(resp_valid), 64'd0);
        check("rst.err", 64'(resp_err), 64'd0);
        check("rst.rdata", resp_rdata, 64'd0);
        reset = 1'b0;

        // 32-bit store/load
        do_req("sw10", 1'b1, 1'b0, 64'h10, 64'h0000_0000_1234_5678);
        do_req("lw10", 1'b0, 1'b0, 64'h10, 64'd0);
        check("lw10.const", model_rdata(1'b0, 1'b0, 64'h10), 64'h0000_0000_1234_5678);

        // 64-bit store/load and sign extension of upper word
        do_req("sd20", 1'b1, 1'b1, 64'h20, 64'hDEAD_BEEF_CAFE_F00D);
        do_req("ld20", 1'b0, 1'b1, 64'h20, 64'd0);
        do_req("lw24", 1'b0, 1'b0, 64'h24, 64'd0);
        check("lw24.const", model_rdata(1'b0, 1'b0, 64'h24), 64'hFFFF_FFFF_DEAD_BEEF);

        // Errors: misaligned, out of range, aliased high bits, erroring store does not write
        do_req("ld24mis", 1'b0, 1'b1, 64'h24, 64'd0);
        do_req("lw400", 1'b0, 1'b0, 64'h400, 64'd0);
        do_req("lwhigh", 1'b0, 1'b0, 64'h0000_0100_0000_0010, 64'd0);
        do_req("sw26mis", 1'b1, 1'b0, 64'h26, 64'h0000_0000_5555_5555);
        do_req("sdhigh", 1'b1, 1'b1, 64'h8000_0000_0000_0020, 64'h0123_4567_89AB_CDEF);
        do_req("lw24b", 1'b0, 1'b0, 64'h24, 64'd0);
        do_req("ld20b", 1'b0, 1'b1, 64'h20, 64'd0);

        // Request held while busy: second request only taken after RESP
        exp_first  = model_rdata(1'b0, 1'b1, 64'h20);
        exp_second = model_rdata(1'b0, 1'b0, 64'h10);
        pulses = 0; first_resp = -1; second_resp = -1; ready_low = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_dbl = 1'b1; req_addr = 64'h20;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_dbl = 1'b0; req_addr = 64'h10;
            end
            if (c == 5) req_valid = 1'b0;
            if (c <= 3 && !req_ready) ready_low++;
            if (resp_valid) begin
                pulses++;
                if (first_resp < 0) begin
                    first_resp = c;
                    check("hold.rd1", resp_rdata, exp_first);
                end else begin
                    second_resp = c;
                    check("hold.rd2", resp_rdata, exp_second);
                end
            end
        end
        check("hold.readylow", 64'(ready_low), 64'd3);
        check("hold.pulses", 64'(pulses), 64'd2);
        check("hold.first", 64'(first_resp), 64'd3);
        check("hold.second", 64'(second_resp), 64'd6);

        // Reset during the second beat of a 64-bit store
        do_req("sd30pre", 1'b1, 1'b1, 64'h30, 64'd0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_dbl = 1'b1; req_addr = 64'h30;
        req_wdata = 64'h1111_1111_2222_2222;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst.ready", 64'(req_ready), 64'd1);
        check("arst.valid", 64'(resp_valid), 64'd0);
        check("arst.err", 64'(resp_err), 64'd0);
        check("arst.rdata", resp_rdata, 64'd0);
        #2;
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid) pulses++;
        end
        check("arst.noresp", 64'(pulses), 64'd0);
        mdl[12] = 32'h2222_2222;
        do_req("lw30", 1'b0, 1'b0, 64'h30, 64'd0);
        do_req("lw34", 1'b0, 1'b0, 64'h34, 64'd0);

        // Fill the whole array so random loads always hit defined words
        for (int w = 0; w < DEPTH; w += 2) begin
            do_req("fill", 1'b1, 1'b1, 64'(w * 4), {$urandom, $urandom});
        end

        // Randomized mix of loads, stores and errors
        for (int n = 0; n < 250; n++) begin
            logic we;
            logic dbl;
            logic [63:0] addr;
            int kind;
            int idx;
            we   = 1'($urandom_range(0, 1));
            dbl  = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, DEPTH - 1);
            if (dbl) idx = idx - (idx % 2);
            addr = 64'(idx) * 4;
            if (kind == 0) begin
                addr = addr + 64'($urandom_range(1, dbl ? 7 : 3));
            end else if (kind == 1) begin
                addr = 64'(DEPTH + $urandom_range(0, 1000)) * 4;
            end else if (kind == 2) begin
                addr = addr | ({32'($urandom_range(1, 255)), 32'd0});
            end
            do_req("rand", we, dbl, addr, {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
